// File: rtl/calc_result_acc_v_pkg.sv
// Shared constants and state encoding for the calculator result accumulator.
package calc_pkg;

   localparam int DATA_W = 9;
   localparam int ACC_W  = 12;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ACCUM = 2'b01,
      HOLD  = 2'b10
   } state_t;

   localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

endpackage

// File: rtl/calc_result_acc_v_if.sv
// Sample-in / statistics-out handshake bundle; master is the upstream/downstream side, slave the accumulator.
interface calc_result_acc_v_if #(
   parameter int DATA_W = calc_pkg::DATA_W,
   parameter int ACC_W  = calc_pkg::ACC_W,
   parameter int CNT_W  = calc_pkg::CNT_W
);

   logic                     i_clear;
   logic                     i_valid;
   logic                     o_ready;
   logic signed [DATA_W-1:0] i_fs;
   logic [CNT_W-1:0]         i_len;
   logic                     o_valid;
   logic                     i_ready;
   logic signed [ACC_W-1:0]  o_sum;
   logic signed [DATA_W-1:0] o_min;
   logic signed [DATA_W-1:0] o_max;
   logic [CNT_W:0]           o_count;
   logic                     o_sat;

   modport master (
      output i_clear, i_valid, i_fs, i_len, i_ready,
      input  o_ready, o_valid, o_sum, o_min, o_max, o_count, o_sat
   );

   modport slave (
      input  i_clear, i_valid, i_fs, i_len, i_ready,
      output o_ready, o_valid, o_sum, o_min, o_max, o_count, o_sat
   );

endinterface

// File: rtl/calc_result_acc_v_sat_add.sv
// Combinational saturating add of a sign-extended sample into the accumulator.
module sat_add_v #(
   parameter int DATA_W = calc_pkg::DATA_W,
   parameter int ACC_W  = calc_pkg::ACC_W
) (
   input  logic signed [ACC_W-1:0]  acc,
   input  logic signed [DATA_W-1:0] sample,
   output logic signed [ACC_W-1:0]  sum,
   output logic                     overflow
);

   logic signed [ACC_W:0] wide;

   // One guard bit is enough because the sample is narrower than the accumulator.
   always_comb begin
      wide     = {acc[ACC_W-1], acc} + {{(ACC_W+1-DATA_W){sample[DATA_W-1]}}, sample};
      overflow = wide[ACC_W] != wide[ACC_W-1];
      if (!overflow)
         sum = wide[ACC_W-1:0];
      else if (wide[ACC_W])
         sum = {1'b1, {(ACC_W-1){1'b0}}};
      else
         sum = {1'b0, {(ACC_W-1){1'b1}}};
   end

endmodule

// File: rtl/calc_result_acc_v.sv
// Frame accumulator: saturating sum, min/max and count over N samples, held until downstream takes it.
module calc_result_acc_v #(
   parameter int DATA_W = calc_pkg::DATA_W,
   parameter int ACC_W  = calc_pkg::ACC_W,
   parameter int CNT_W  = calc_pkg::CNT_W
) (
   input logic               i_clk,
   input logic               i_rst_n,
   calc_result_acc_v_if.slave bus
);

   import calc_pkg::*;

   state_t                   state;
   state_t                   next_state;
   logic signed [ACC_W-1:0]  sum_q;
   logic signed [ACC_W-1:0]  sum_add;
   logic                     add_ovf;
   logic signed [DATA_W-1:0] min_q;
   logic signed [DATA_W-1:0] max_q;
   logic [CNT_W:0]           count_q;
   logic [CNT_W:0]           len_q;
   logic [CNT_W:0]           len_first;
   logic                     sat_q;
   logic                     accept;

   assign accept    = bus.i_valid && bus.o_ready;
   assign len_first = (bus.i_len == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, bus.i_len};

   sat_add_v #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_sat_add (
      .acc      (sum_q),
      .sample   (bus.i_fs),
      .sum      (sum_add),
      .overflow (add_ovf)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (bus.i_clear) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:    if (accept)
                        next_state = (len_first == {{CNT_W{1'b0}}, 1'b1}) ? HOLD : ACCUM;
            ACCUM:   if (accept && ((count_q + 1'b1) == len_q))
                        next_state = HOLD;
            HOLD:    if (bus.i_ready)
                        next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   always_comb begin
      bus.o_ready = (state != HOLD);
      bus.o_valid = (state == HOLD);
   end

   // Statistics only move on an accepted sample; HOLD never accepts, so they stay stable there.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sum_q   <= '0;
         min_q   <= '0;
         max_q   <= '0;
         count_q <= '0;
         len_q   <= '0;
         sat_q   <= 1'b0;
      end else if (bus.i_clear) begin
         sum_q   <= '0;
         min_q   <= '0;
         max_q   <= '0;
         count_q <= '0;
         len_q   <= '0;
         sat_q   <= 1'b0;
      end else if (accept) begin
         if (state == IDLE) begin
            sum_q   <= {{(ACC_W-DATA_W){bus.i_fs[DATA_W-1]}}, bus.i_fs};
            min_q   <= bus.i_fs;
            max_q   <= bus.i_fs;
            count_q <= {{CNT_W{1'b0}}, 1'b1};
            len_q   <= len_first;
            sat_q   <= 1'b0;
         end else begin
            sum_q   <= sum_add;
            sat_q   <= sat_q | add_ovf;
            count_q <= count_q + 1'b1;
            if (bus.i_fs < min_q)
               min_q <= bus.i_fs;
            if (bus.i_fs > max_q)
               max_q <= bus.i_fs;
         end
      end
   end

   assign bus.o_sum   = sum_q;
   assign bus.o_min   = min_q;
   assign bus.o_max   = max_q;
   assign bus.o_count = count_q;
   assign bus.o_sat   = sat_q;

endmodule

// File: tb/tb_calc_result_acc_v.sv
// Scoreboard bench: driver pushes the modelled frame statistics, a monitor pops them on each result handshake.
module tb_calc_result_acc_v;

   import calc_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   calc_result_acc_v_if bus ();

   calc_result_acc_v dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   typedef struct {
      int sum;
      int mn;
      int mx;
      int cnt;
      int sat;
   } exp_t;

   exp_t sb[$];
   exp_t lastExp;
   int   frameSamples[$];
   int   vectors     = 0;
   int   miscompares = 0;

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Reference: plain integer sum clipped after every step, min/max over the sample list.
   function automatic exp_t modelFrame();
      exp_t e;
      int   acc;
      int   hi;
      int   lo;
      hi    = (1 << (ACC_W-1)) - 1;
      lo    = -(1 << (ACC_W-1));
      acc   = 0;
      e.sat = 0;
      e.cnt = frameSamples.size();
      e.mn  = frameSamples[0];
      e.mx  = frameSamples[0];
      foreach (frameSamples[i]) begin
         acc = acc + frameSamples[i];
         if (acc > hi) begin
            acc   = hi;
            e.sat = 1;
         end else if (acc < lo) begin
            acc   = lo;
            e.sat = 1;
         end
         if (frameSamples[i] < e.mn) e.mn = frameSamples[i];
         if (frameSamples[i] > e.mx) e.mx = frameSamples[i];
      end
      e.sum = acc;
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected result: got sum %0d, expected no frame", int'(bus.o_sum));
         end else begin
            e = sb.pop_front();
            checkOutput("sum",   int'(bus.o_sum),   e.sum);
            checkOutput("min",   int'(bus.o_min),   e.mn);
            checkOutput("max",   int'(bus.o_max),   e.mx);
            checkOutput("count", int'(bus.o_count), e.cnt);
            checkOutput("sat",   int'(bus.o_sat),   e.sat);
         end
      end
   end

   // Leaves i_valid high; returns #1 after the edge that accepted the sample.
   task automatic applySample(input int fs);
      logic rdy;
      bit   accepted;
      accepted    = 1'b0;
      bus.i_valid = 1'b1;
      bus.i_fs    = DATA_W'(fs);
      for (int t = 0; t < 50 && !accepted; t++) begin
         @(negedge clk);
         rdy = bus.o_ready;
         @(posedge clk);
         #1;
         if (rdy) accepted = 1'b1;
      end
      if (!accepted) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL accept timeout: got o_ready 0, expected 1 within 50 cycles");
      end
   endtask

   task automatic applyStimulus(input logic [CNT_W-1:0] len, input int gapMode, input int holdCycles);
      exp_t e;
      int   g;
      e = modelFrame();
      sb.push_back(e);
      lastExp     = e;
      bus.i_ready = (holdCycles == 0);
      bus.i_len   = len;
      for (int k = 0; k < frameSamples.size(); k++) begin
         if (k > 0) begin
            g = (gapMode == 1) ? 1 : (gapMode == 2) ? int'($urandom_range(0, 2)) : 0;
            if (g > 0) begin
               bus.i_valid = 1'b0;
               bus.i_fs    = DATA_W'($urandom);
               repeat (g) begin
                  @(posedge clk);
                  #1;
               end
            end
         end
         applySample(frameSamples[k]);
         if (k == 0) bus.i_len = CNT_W'($urandom);
         if (k < frameSamples.size() - 1)
            checkOutput("valid mid-frame", int'(bus.o_valid), 0);
      end
      checkOutput("valid latency", int'(bus.o_valid), 1);
      bus.i_valid = (holdCycles > 0);
      bus.i_fs    = DATA_W'(99);
      repeat (holdCycles) begin
         @(negedge clk);
         checkOutput("hold valid", int'(bus.o_valid), 1);
         checkOutput("hold ready", int'(bus.o_ready), 0);
         checkOutput("hold sum",   int'(bus.o_sum),   lastExp.sum);
         checkOutput("hold count", int'(bus.o_count), lastExp.cnt);
         @(posedge clk);
         #1;
      end
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("valid drop",      int'(bus.o_valid), 0);
      checkOutput("ready return",    int'(bus.o_ready), 1);
      checkOutput("sum after frame", int'(bus.o_sum),   lastExp.sum);
      checkOutput("count after",     int'(bus.o_count), lastExp.cnt);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before 200000 time units");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int len;
      int n;
      bus.i_clear = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_fs    = '0;
      bus.i_len   = '0;
      bus.i_ready = 1'b0;
      rst_n       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset sum",   int'(bus.o_sum),   0);
      checkOutput("reset min",   int'(bus.o_min),   0);
      checkOutput("reset max",   int'(bus.o_max),   0);
      checkOutput("reset count", int'(bus.o_count), 0);
      checkOutput("reset sat",   int'(bus.o_sat),   0);
      checkOutput("reset valid", int'(bus.o_valid), 0);
      checkOutput("reset ready", int'(bus.o_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      frameSamples = '{10, -20, 30, -5};
      applyStimulus(4, 0, 0);

      frameSamples.delete();
      repeat (16) frameSamples.push_back(255);
      applyStimulus(0, 0, 0);

      frameSamples.delete();
      repeat (16) frameSamples.push_back(-256);
      applyStimulus(0, 0, 0);

      frameSamples = '{7, -3, 12};
      applyStimulus(3, 0, 5);

      frameSamples = '{-128};
      applyStimulus(1, 0, 0);

      frameSamples = '{5, 6, 7};
      applyStimulus(3, 1, 0);

      // Clear after two samples; the sample presented alongside the clear must be dropped.
      bus.i_len = 4'd4;
      applySample(40);
      applySample(-9);
      bus.i_fs    = DATA_W'(77);
      bus.i_clear = 1'b1;
      @(posedge clk);
      #1;
      bus.i_clear = 1'b0;
      bus.i_valid = 1'b0;
      checkOutput("clear sum",   int'(bus.o_sum),   0);
      checkOutput("clear min",   int'(bus.o_min),   0);
      checkOutput("clear max",   int'(bus.o_max),   0);
      checkOutput("clear count", int'(bus.o_count), 0);
      checkOutput("clear sat",   int'(bus.o_sat),   0);
      checkOutput("clear valid", int'(bus.o_valid), 0);
      checkOutput("clear ready", int'(bus.o_ready), 1);
      frameSamples = '{1, 2, 3, 4};
      applyStimulus(4, 0, 0);

      bus.i_len = 4'd4;
      applySample(100);
      applySample(50);
      bus.i_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async sum",   int'(bus.o_sum),   0);
      checkOutput("async count", int'(bus.o_count), 0);
      checkOutput("async valid", int'(bus.o_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("ready after reset", int'(bus.o_ready), 1);

      for (int f = 0; f < 24; f++) begin
         len = int'($urandom_range(0, 15));
         n   = (len == 0) ? 16 : len;
         frameSamples.delete();
         for (int s = 0; s < n; s++) begin
            if (f % 4 == 0)
               frameSamples.push_back(($urandom_range(0, 1) == 1) ? 255 : -256);
            else
               frameSamples.push_back(int'($urandom_range(0, 511)) - 256);
         end
         applyStimulus(CNT_W'(len), 2, int'($urandom_range(0, 3)));
      end

      repeat (3) @(posedge clk);
      #1;
      checkOutput("scoreboard drain", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
